axil_arbiter_rr_rd: RTL

- Read-side companion to the write-channel priority arbiter in the AXI-Lite interconnect.
- Arbitrates NUMBER_MASTER AXI-Lite read masters onto a single slave port using round-robin.
- Muxes the granted master's AR channel to the slave and routes the R response back to that master.
- Holds one outstanding read: the grant lives from AR request until the R handshake completes.

---
 rtl/axil_arbiter_rr_rd_if.sv | 38 +++
 rtl/axil_arbiter_rr_rd.sv | 138 +++++++++++++
 2 files changed

// File: rtl/axil_arbiter_rr_rd_if.sv
// AXI-Lite read channel bundle (AR + R) with NUM_PORTS parallel lanes.
// The arbiter uses a NUM_PORTS-lane instance toward its masters and a
// single-lane instance toward its slave. rdata/rresp are shared by all lanes.
//
// Signals:
//   arvalid [NUM_PORTS]             AR valid per lane
//   araddr  [NUM_PORTS*ADDR_WIDTH]  lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   arready [NUM_PORTS]             AR ready per lane
//   rdata   [DATA_WIDTH]            read data, common to all lanes
//   rresp   [2]                     read response, common to all lanes
//   rvalid  [NUM_PORTS]             R valid per lane
//   rready  [NUM_PORTS]             R ready per lane
// Modports:
//   master  issues reads (drives arvalid/araddr/rready)
//   slave   serves reads (drives arready/rdata/rresp/rvalid)
interface axil_arbiter_rr_rd_if #(
  parameter int unsigned NUM_PORTS  = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [NUM_PORTS-1:0]            arvalid;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] araddr;
  logic [NUM_PORTS-1:0]            arready;
  logic [DATA_WIDTH-1:0]           rdata;
  logic [1:0]                      rresp;
  logic [NUM_PORTS-1:0]            rvalid;
  logic [NUM_PORTS-1:0]            rready;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_arbiter_rr_rd.sv
// Round-robin arbiter for NUMBER_MASTER AXI-Lite read masters sharing one
// slave port. One read is outstanding at a time: a master is granted in IDLE,
// its AR is forwarded in ADDR, and its R beat is returned in DATA. The grant
// is released on the R handshake, after which the round-robin pointer moves
// to the master following the one just served.
//
// Ports:
//   aclk      clock
//   aresetn   asynchronous active-low reset
//   m_axil    NUMBER_MASTER-lane read bus from the masters (arbiter serves)
//   s_axil    single-lane read bus to the slave (arbiter issues)
//   grant_rd  one-hot current grant, 0 when idle
//
// NUMBER_MASTER must be at least 2.
module axil_arbiter_rr_rd #(
  parameter int unsigned NUMBER_MASTER = 2,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axil_arbiter_rr_rd_if.slave      m_axil,
  axil_arbiter_rr_rd_if.master     s_axil,
  output logic [NUMBER_MASTER-1:0] grant_rd
);

  localparam int unsigned PtrW = $clog2(NUMBER_MASTER);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [NUMBER_MASTER-1:0] grant_q, grant_d;
  logic [PtrW-1:0]          rr_ptr_q, rr_ptr_d;

  logic [NUMBER_MASTER-1:0] win_hi, win_lo, winner_oh;
  logic                     found_hi, found_lo;
  logic [PtrW-1:0]          ptr_next;
  logic [ADDR_WIDTH-1:0]    araddr_sel;
  logic                     arvalid_g, rready_g;
  logic                     in_addr, in_data;
  logic                     s_arvalid;

  // Winner: lowest requester at or above rr_ptr; if none, lowest requester
  // overall, which is the wrap-around part of the circular scan.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      if (m_axil.arvalid[i] && (PtrW'(i) >= rr_ptr_q) && !found_hi) begin
        win_hi[i] = 1'b1;
        found_hi  = 1'b1;
      end
      if (m_axil.arvalid[i] && !found_lo) begin
        win_lo[i] = 1'b1;
        found_lo  = 1'b1;
      end
    end
    winner_oh = found_hi ? win_hi : win_lo;
  end

  // Granted-master selects, driven straight from the one-hot grant.
  always_comb begin
    araddr_sel = '0;
    ptr_next   = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      if (grant_q[i]) begin
        araddr_sel = araddr_sel | m_axil.araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        // Explicit wrap so non-power-of-2 counts never point past the end.
        ptr_next   = (i == NUMBER_MASTER - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end

  assign arvalid_g = |(m_axil.arvalid & grant_q);
  assign rready_g  = |(m_axil.rready & grant_q);
  assign in_addr   = (state_q == StAddr);
  assign in_data   = (state_q == StData);
  assign s_arvalid = in_addr & arvalid_g;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (|m_axil.arvalid) begin
          grant_d = winner_oh;
          state_d = StAddr;
        end
      end
      StAddr: begin
        // A granted master that drops arvalid keeps its grant and waits here.
        if (s_arvalid && s_axil.arready[0]) begin
          state_d = StData;
        end
      end
      StData: begin
        if (s_axil.rvalid[0] && rready_g) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = ptr_next;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Handshake outputs are qualified by the registered state so an async reset
  // clears them immediately, without waiting for a clock edge.
  assign s_axil.arvalid = s_arvalid;
  assign s_axil.araddr  = araddr_sel;
  assign s_axil.rready  = in_data & rready_g;
  assign m_axil.arready = in_addr ? (grant_q & {NUMBER_MASTER{s_axil.arready[0]}}) : '0;
  assign m_axil.rvalid  = in_data ? (grant_q & {NUMBER_MASTER{s_axil.rvalid[0]}}) : '0;
  assign m_axil.rdata   = s_axil.rdata;
  assign m_axil.rresp   = s_axil.rresp;
  assign grant_rd       = grant_q;

endmodule
